fsm_ring_timeout: RTL

//  Parametrised Moore FSM with STATE_CNT states (idle = 0), driven by two control inputs a/b.

---
 rtl/fsm_ring_timeout_pkg.sv | 26 ++
 rtl/fsm_ring_timeout_if.sv | 25 ++
 rtl/fsm_ring_timeout_dwell_timer.sv | 37 +++
 rtl/fsm_ring_timeout.sv | 86 ++++++++
 4 files changed

// File: rtl/fsm_ring_timeout_pkg.sv
// Shared definitions for the ring FSM: idle encoding, width helper and
// the input-driven next-state rule (timeout handling lives in the top).
package fsm_ring_pkg;

  localparam int unsigned ST_IDLE = 0;

  // Ceiling log2, usable in constant expressions for derived widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Input-driven next state, first match wins: a&b, a&~b, ~a&b, else hold.
  function automatic int unsigned ring_next(input int unsigned st,
                                            input logic        a,
                                            input logic        b,
                                            input int unsigned state_cnt);
    if (a && b)      return state_cnt - 1;
    else if (a)      return ST_IDLE;
    else if (b)      return (st == state_cnt - 1) ? ST_IDLE : st + 1;
    else             return st;
  endfunction

endpackage

// File: rtl/fsm_ring_timeout_if.sv
// Control/status bundle of the ring FSM: controller drives en/a/b and
// observes state, decoded output, pulses and the transition count.
interface fsm_ring_timeout_if #(
  parameter int ST_W      = 2,
  parameter int CNT_WIDTH = 16
);
  logic                 en;
  logic                 a;
  logic                 b;
  logic [ST_W-1:0]      dout;
  logic [ST_W-1:0]      st_o;
  logic                 changed;
  logic                 timeout_o;
  logic [CNT_WIDTH-1:0] trans_cnt;

  modport master (
    output en, a, b,
    input  dout, st_o, changed, timeout_o, trans_cnt
  );

  modport slave (
    input  en, a, b,
    output dout, st_o, changed, timeout_o, trans_cnt
  );
endinterface

// File: rtl/fsm_ring_timeout_dwell_timer.sv
// Dwell timer: counts enabled cycles spent in a non-idle state with no
// input activity and flags the last cycle before a forced idle return.
module dwell_timer
  import fsm_ring_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic run,
  output logic hit
);

  // A TIMEOUT of 0 disables the timer; keep a 1-bit counter so widths stay legal.
  localparam int CW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt;

  // Count dwell cycles; activity, a state change or sitting in idle restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      if (clr || !run) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

  // Expiry flag for the current cycle; never asserted when the timer is disabled.
  always_comb begin
    hit = (TIMEOUT > 0) && run && (cnt == LAST);
  end

endmodule

// File: rtl/fsm_ring_timeout.sv
// Ring-style Moore FSM driven by a/b with per-state dwell timeout back to
// idle, global enable, change/timeout pulses and a wrapping change counter.
module fsm_ring_timeout
  import fsm_ring_pkg::*;
#(
  parameter int STATE_CNT = 3,
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fsm_ring_timeout_if.slave  bus
);

  localparam int ST_W = clog2(STATE_CNT + 1);

  logic [ST_W-1:0]      st;
  logic [ST_W-1:0]      st_nx;
  logic                 take_timeout;
  logic                 hit;
  logic                 dwell_clr;
  logic                 dwell_run;
  logic                 changed_q;
  logic                 timeout_q;
  logic [CNT_WIDTH-1:0] trans_cnt_q;

  // Dwell clears on any input activity or state change and only runs outside idle.
  always_comb begin
    dwell_run = (st != ST_W'(ST_IDLE));
    dwell_clr = bus.en && (bus.a || bus.b || (st_nx != st));
  end

  dwell_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (dwell_clr),
    .run   (dwell_run),
    .hit   (hit)
  );

  // State register: reset forces idle regardless of enable or inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) st <= ST_W'(ST_IDLE);
    else        st <= st_nx;
  end

  // Next state: input transitions first, timeout only when both inputs are low.
  always_comb begin
    st_nx        = ST_W'(ring_next(32'(st), bus.a, bus.b, 32'(STATE_CNT)));
    take_timeout = 1'b0;
    if (!bus.a && !bus.b && hit) begin
      st_nx        = ST_W'(ST_IDLE);
      take_timeout = 1'b1;
    end
    if (!bus.en) begin
      st_nx        = st;
      take_timeout = 1'b0;
    end
  end

  // Change/timeout pulses and wrapping change counter; self-loops do not count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      changed_q   <= 1'b0;
      timeout_q   <= 1'b0;
      trans_cnt_q <= '0;
    end else begin
      changed_q <= (st_nx != st);
      timeout_q <= take_timeout;
      if (st_nx != st) trans_cnt_q <= trans_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Moore outputs decoded from registered state.
  always_comb begin
    bus.st_o      = st;
    bus.dout      = st + ST_W'(1);
    bus.changed   = changed_q;
    bus.timeout_o = timeout_q;
    bus.trans_cnt = trans_cnt_q;
  end

endmodule
